// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the NPU feature-map pipeline. The activation stage,
// the pooling stage and later stages all import this package, so the pixel
// width is defined in exactly one place.
//   DATA_W    : width of a post-ReLU activation pixel
//   pixel_t   : one pixel, treated as unsigned
//   pixel_max : unsigned maximum of two pixels (ties return that value)
// ---------------------------------------------------------------------------
package npu_pkg;

  localparam int DATA_W = 22;

  typedef logic [DATA_W-1:0] pixel_t;

  function automatic pixel_t pixel_max(input pixel_t a, input pixel_t b);
    pixel_t m;
    if (a >= b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// ---------------------------------------------------------------------------
// pool_line_buffer
// Half-width line buffer holding the horizontal pair maxima of the upper row
// of each 2x2 window. Register array with a combinational read port.
//   clk      : clock
//   rst      : asynchronous active-high reset, clears the array
//   i_we     : write enable (asserted only on even rows)
//   i_waddr  : write index
//   i_wdata  : pair maximum to store
//   i_raddr  : read index
//   o_rdata  : stored pair maximum at i_raddr (combinational)
// ---------------------------------------------------------------------------
module pool_line_buffer
  import npu_pkg::*;
#(
  parameter int DEPTH  = 13,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  pixel_t            i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output pixel_t            o_rdata
);

  pixel_t r_mem [DEPTH];

  // Storage array; clearing it on reset keeps the read data at zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// ---------------------------------------------------------------------------
// max_pool_2x2
// Streaming 2x2 / stride-2 max pooling of a raster-order pixel stream.
// The upper row of every window is reduced to pair maxima in a half-width
// line buffer; the lower row completes the window and produces one result.
//   clk          : clock
//   rst          : asynchronous active-high reset
//   pixel_valid  : pixel_in valid this cycle (no backpressure)
//   pixel_in     : post-ReLU pixel, unsigned
//   result_valid : one-cycle strobe, result_out holds a new window maximum
//   result_out   : maximum of the last completed window (held between results)
//   frame_done   : one-cycle pulse after the last pixel of a frame
// ---------------------------------------------------------------------------
module max_pool_2x2
  import npu_pkg::*;
#(
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   pixel_valid,
  input  pixel_t pixel_in,
  output logic   result_valid,
  output pixel_t result_out,
  output logic   frame_done
);

  localparam int COL_W  = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int K_W    = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  pixel_t           r_pair;
  logic             r_result_valid;
  pixel_t           r_result_out;
  logic             r_frame_done;

  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_pair_done;
  logic             w_lb_we;
  logic             w_win_done;
  logic [K_W-1:0]   w_k;
  pixel_t           w_pair_max;
  pixel_t           w_lb_rdata;

  assign w_last_col  = (r_col == COL_W'(IMG_WIDTH - 1));
  assign w_last_row  = (r_row == ROW_W'(IMG_HEIGHT - 1));
  // An odd column always closes a horizontal pair; with an odd width the
  // trailing even column never reaches this point and is simply dropped.
  assign w_pair_done = pixel_valid & r_col[0];
  assign w_lb_we     = w_pair_done & ~r_row[0];
  // With an odd height the last row is even, so it only writes the buffer.
  assign w_win_done  = w_pair_done & r_row[0];
  assign w_k         = K_W'(r_col >> 1);
  assign w_pair_max  = pixel_max(r_pair, pixel_in);

  pool_line_buffer #(
    .DEPTH  (HALF_W),
    .ADDR_W (K_W)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_lb_we),
    .i_waddr (w_k),
    .i_wdata (w_pair_max),
    .i_raddr (w_k),
    .o_rdata (w_lb_rdata)
  );

  // Raster position: column/row advance on accepted pixels and wrap per frame.
  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (pixel_valid) begin
      if (w_last_col) begin
        w_col_nxt = '0;
        if (w_last_row) begin
          w_row_nxt = '0;
        end else begin
          w_row_nxt = r_row + ROW_W'(1);
        end
      end else begin
        w_col_nxt = r_col + COL_W'(1);
        w_row_nxt = r_row;
      end
    end else begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
    end
  end

  // Position counters and the left pixel of the current horizontal pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_pair <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      if (pixel_valid && !r_col[0]) begin
        r_pair <= pixel_in;
      end
    end
  end

  // Output registers: strobes are single-cycle, result_out holds its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result_valid <= 1'b0;
      r_result_out   <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_result_valid <= w_win_done;
      r_frame_done   <= pixel_valid & w_last_col & w_last_row;
      if (w_win_done) begin
        r_result_out <= pixel_max(w_lb_rdata, w_pair_max);
      end
    end
  end

  assign result_valid = r_result_valid;
  assign result_out   = r_result_out;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench: a 4x4 and a 5x5 instance share clock and reset.
// Expected outputs are computed from the frame contents with plain arithmetic.
module tb_max_pool_2x2;
  import npu_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   pv4, pv5;
  pixel_t pin4, pin5;
  logic   rv4, rv5, fd4, fd5;
  pixel_t ro4, ro5;

  int checks   = 0;
  int failures = 0;

  int unsigned frm [8][8];
  int unsigned last_res [2];
  int          done_cnt;

  always #5 clk = ~clk;

  max_pool_2x2 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .pixel_valid(pv4), .pixel_in(pin4),
    .result_valid(rv4), .result_out(ro4), .frame_done(fd4));

  max_pool_2x2 #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
    .clk(clk), .rst(rst), .pixel_valid(pv5), .pixel_in(pin5),
    .result_valid(rv5), .result_out(ro5), .frame_done(fd5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input int unsigned d);
    if (sel == 0) begin
      pv4 = v; pin4 = pixel_t'(d);
    end else begin
      pv5 = v; pin5 = pixel_t'(d);
    end
  endtask

  task automatic check_outs(input int sel, input string tag, input logic exp_v, input logic exp_d);
    logic   v, d;
    pixel_t o;
    v = (sel == 0) ? rv4 : rv5;
    d = (sel == 0) ? fd4 : fd5;
    o = (sel == 0) ? ro4 : ro5;
    check({tag, "_valid"}, {31'd0, v}, {31'd0, exp_v});
    check({tag, "_data"}, {10'd0, o}, last_res[sel]);
    check({tag, "_done"}, {31'd0, d}, {31'd0, exp_d});
    if (d) done_cnt++;
  endtask

  // Send the first npix pixels of frm in raster order with 0..max_gap idle cycles.
  task automatic send_frame(input int sel, input int npix, input int max_gap, input string tag);
    int w, h, r, c, gap;
    logic win, last;
    w = (sel == 0) ? 4 : 5;
    h = w;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / w;
      c = idx % w;
      drive(sel, 1'b1, frm[r][c]);
      @(posedge clk); #1;
      win  = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2));
      last = (r == h - 1) && (c == w - 1);
      if (win) begin
        last_res[sel] = frm[r-1][c-1];
        if (frm[r-1][c] > last_res[sel]) last_res[sel] = frm[r-1][c];
        if (frm[r][c-1] > last_res[sel]) last_res[sel] = frm[r][c-1];
        if (frm[r][c]   > last_res[sel]) last_res[sel] = frm[r][c];
      end
      check_outs(sel, tag, win, last);
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        drive(sel, 1'b0, 0);
        @(posedge clk); #1;
        check_outs(sel, {tag, "_idle"}, 1'b0, 1'b0);
      end
    end
    drive(sel, 1'b0, 0);
  endtask

  task automatic fill_const(input int unsigned v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) frm[r][c] = v;
  endtask

  task automatic fill_ramp(input int w);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) frm[r][c] = w * r + c;
  endtask

  task automatic fill_rand(input int unsigned mask);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) frm[r][c] = $urandom() & mask;
  endtask

  initial begin
    rst = 1'b1;
    pv4 = 1'b0; pv5 = 1'b0; pin4 = '0; pin5 = '0;
    last_res[0] = 0; last_res[1] = 0;
    done_cnt = 0;
    #12;
    check_outs(0, "rst4", 1'b0, 1'b0);
    check_outs(1, "rst5", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 4x4 ramp, continuous then with random idle gaps: 5, 7, 13, 15
    fill_ramp(4);
    send_frame(0, 16, 0, "ramp4");
    send_frame(0, 16, 3, "ramp4_gap");

    // Maximum in each window corner, then an all-equal tie frame
    fill_const(0);
    frm[0][0] = 9; frm[0][3] = 9; frm[3][0] = 9; frm[3][3] = 9;
    send_frame(0, 16, 0, "corner");
    fill_const(7);
    send_frame(0, 16, 1, "tie");

    // Odd geometry: column 4 and row 4 are dropped: 6, 8, 16, 18
    done_cnt = 0;
    fill_ramp(5);
    send_frame(1, 25, 0, "ramp5");
    check("ramp5_frames", done_cnt, 1);
    fill_rand(32'h003F_FFFF);
    send_frame(1, 25, 2, "rand5");

    // Reset mid-frame discards the partial window
    fill_rand(32'h003F_FFFF);
    send_frame(0, 6, 0, "pre_rst");
    #2 rst = 1'b1;
    #2;
    last_res[0] = 0; last_res[1] = 0;
    check_outs(0, "mid_rst4", 1'b0, 1'b0);
    check_outs(1, "mid_rst5", 1'b0, 1'b0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    fill_const(1);
    frm[2][2] = 3;
    send_frame(0, 16, 0, "post_rst");

    // Back-to-back frames carrying a full-scale maximum
    done_cnt = 0;
    fill_rand(32'h003F_FFFE);
    frm[1][2] = 32'h003F_FFFF;
    send_frame(0, 16, 0, "b2b_a");
    fill_rand(32'h003F_FFFE);
    frm[2][1] = 32'h003F_FFFF;
    send_frame(0, 16, 0, "b2b_b");
    check("b2b_frames", done_cnt, 2);

    // Random data with random gaps
    for (int f = 0; f < 3; f++) begin
      fill_rand(32'h003F_FFFF);
      send_frame(0, 16, 3, "rand4");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
